// File: rtl/otter_pkg.sv
// Shared OTTER definitions: RV32I opcodes, control-unit states and the mret func3 code.
// Imported by the control-unit FSM and by the combinational decoder.
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LW     = 7'b0000011,
    SW     = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    CSR    = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } cu_state_t;

  localparam logic [2:0] F3_MRET = 3'b000;

endpackage

// File: rtl/otter_cu_fsm_mem_wait_ctr.sv
// Memory-latency wait counter shared by instruction fetch and load writeback.
// done_o marks the last cycle of a MEM_LAT-cycle memory access.
module mem_wait_ctr #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic done_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= 4'd0;
    else if (en_i)    cnt_q <= cnt_q + 4'd1;
  end

  assign done_o = (cnt_q == 4'(MEM_LAT - 1));

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle control unit for the OTTER RV32I core: fetch, execute, load writeback
// and interrupt entry, with memory accesses stretched to MEM_LAT cycles.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       intr,
  input  logic       csr_mie,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_we2,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       rf_reset,
  output logic       csr_we,
  output logic       int_taken,
  output logic       mret_exec
);

  cu_state_t state_q, state_d;
  logic      wait_en, wait_done;
  logic      irq_go;

  // The counter only runs while a memory access is outstanding and self-clears on its last cycle.
  assign wait_en = (state_q == ST_FETCH) || (state_q == ST_WB);
  assign irq_go  = intr && csr_mie;

  mem_wait_ctr #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .en_i   (wait_en),
    .clr_i  (wait_en && wait_done),
    .done_o (wait_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_we2   = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    rf_reset  = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    case (state_q)
      ST_INIT: begin
        rf_reset = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rden1 = 1'b1;
        if (wait_done) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          LUI, AUIPC, OP_IMM, OP_RG3, JAL, JALR: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
          end
          BRANCH: pc_write = 1'b1;
          SW: begin
            pc_write = 1'b1;
            mem_we2  = 1'b1;
          end
          LW: mem_rden2 = 1'b1;
          CSR: begin
            pc_write = 1'b1;
            if (func3 == F3_MRET) begin
              mret_exec = 1'b1;
            end else begin
              reg_write = 1'b1;
              csr_we    = 1'b1;
            end
          end
          default: ;
        endcase
        if (opcode == LW) state_d = ST_WB;
        else              state_d = irq_go ? ST_INTR : ST_FETCH;
      end
      ST_WB: begin
        mem_rden2 = 1'b1;
        if (wait_done) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          state_d   = irq_go ? ST_INTR : ST_FETCH;
        end
      end
      ST_INTR: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Scoreboard bench for otter_cu_fsm: stimulus queues the expected output word for
// every cycle, a negedge monitor pops and compares it against the DUT outputs.
module tb_otter_cu_fsm;
  localparam int ML = 3;

  // Output word bit positions
  localparam logic [8:0] PCW = 9'b1_0000_0000;
  localparam logic [8:0] RGW = 9'b0_1000_0000;
  localparam logic [8:0] WE2 = 9'b0_0100_0000;
  localparam logic [8:0] RD1 = 9'b0_0010_0000;
  localparam logic [8:0] RD2 = 9'b0_0001_0000;
  localparam logic [8:0] RFR = 9'b0_0000_1000;
  localparam logic [8:0] CWE = 9'b0_0000_0100;
  localparam logic [8:0] INT = 9'b0_0000_0010;
  localparam logic [8:0] MRT = 9'b0_0000_0001;
  localparam logic [8:0] NIL = 9'b0_0000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic       intr = 1'b0;
  logic       csr_mie = 1'b0;
  logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rf_reset, csr_we, int_taken, mret_exec;

  typedef struct {
    logic [8:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  otter_cu_fsm #(.MEM_LAT(ML)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .func3     (func3),
    .intr      (intr),
    .csr_mie   (csr_mie),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem_we2   (mem_we2),
    .mem_rden1 (mem_rden1),
    .mem_rden2 (mem_rden2),
    .rf_reset  (rf_reset),
    .csr_we    (csr_we),
    .int_taken (int_taken),
    .mret_exec (mret_exec)
  );

  wire [8:0] outs = {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
                     rf_reset, csr_we, int_taken, mret_exec};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.nm, outs, e.v);
      end
      checks++;
      if ((int_taken && mret_exec) || (mem_we2 && mem_rden2)) begin
        errors++;
        $display("FAIL %s_invariant: got %b want exclusive int/mret and we2/rden2", e.nm, outs);
      end
    end
  end

  task automatic step(input string nm, input logic [8:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One instruction: ML fetch cycles, EXEC, optional ML-cycle writeback, optional INTR.
  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic [8:0] ex, input bit ld, input bit irq, input bit mie,
                     input bit irq_fetch);
    opcode  = op;
    func3   = f3;
    csr_mie = mie;
    intr    = irq_fetch;
    for (int i = 0; i < ML; i++) step({nm, "_fetch"}, RD1);
    intr = irq;
    step({nm, "_exec"}, ex);
    if (ld)
      for (int i = 0; i < ML; i++)
        step({nm, "_wb"}, (i == ML - 1) ? (RD2 | PCW | RGW) : RD2);
    intr = 1'b0;
    if (irq && mie) step({nm, "_intr"}, INT | PCW);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("reset_init", RFR);

    run("addi0",  7'b0010011, 3'b000, PCW | RGW, 0, 0, 0, 0);
    run("addi1",  7'b0010011, 3'b000, PCW | RGW, 0, 0, 0, 0);
    run("lw",     7'b0000011, 3'b010, RD2,       1, 0, 0, 0);
    run("sw_irq", 7'b0100011, 3'b010, PCW | WE2, 0, 1, 1, 0);
    run("sw_mie0",7'b0100011, 3'b010, PCW | WE2, 0, 1, 0, 0);
    run("addi_fetchirq", 7'b0010011, 3'b000, PCW | RGW, 0, 0, 1, 1);
    run("lw_irq", 7'b0000011, 3'b010, RD2,       1, 1, 1, 0);
    run("mret",   7'b1110011, 3'b000, PCW | MRT, 0, 1, 0, 0);
    run("csrrw",  7'b1110011, 3'b001, PCW | RGW | CWE, 0, 0, 0, 0);
    run("branch", 7'b1100011, 3'b000, PCW,       0, 0, 0, 0);
    run("jal",    7'b1101111, 3'b000, PCW | RGW, 0, 0, 0, 0);
    run("lui",    7'b0110111, 3'b000, PCW | RGW, 0, 0, 0, 0);
    run("nop",    7'b0000000, 3'b000, NIL,       0, 1, 1, 0);
    run("op_rg3", 7'b0110011, 3'b000, PCW | RGW, 0, 0, 0, 0);

    // Reset in the second writeback cycle of a load.
    opcode = 7'b0000011;
    func3  = 3'b010;
    for (int i = 0; i < ML; i++) step("rstld_fetch", RD1);
    step("rstld_exec", RD2);
    step("rstld_wb0", RD2);
    rst = 1'b1;
    step("rstld_wb1", RD2);
    rst = 1'b0;
    step("rstld_init", RFR);
    run("post_rst_addi", 7'b0010011, 3'b000, PCW | RGW, 0, 0, 0, 0);

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
